// File: rtl/load_store_queue_fwd.sv
// load_store_queue_fwd
//   Load/store queue between LSU address generation, ROB retire and the
//   data-memory port. Stores sit in a program-ordered circular queue, are
//   committed in order by the ROB and drained to memory with byte strobes.
//   Loads are served in order; each one forwards from the youngest older
//   store(s) when the bytes are fully covered, stalls on partial overlap and
//   otherwise reads memory with a ready/valid handshake.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush_i                  drop speculative loads and uncommitted stores
//   st_*_i / st_ready_o      store enqueue, st_id_o = slot allocated
//   retire_st_valid_i        commit the oldest uncommitted store
//   ld_*_i / ld_ready_o      load enqueue
//   wb_*_o                   load writeback (one-cycle pulse)
//   mem_rd_* / mem_rdata_*   memory read request and response
//   mem_wr_* / mem_w*_o      memory write (drain of committed stores)
module load_store_queue_fwd #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SQ_DEPTH   = 8,
    parameter int LQ_DEPTH   = 8,
    parameter int ROB_WIDTH  = 5,
    parameter int PHY_WIDTH  = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        st_valid_i,
    output logic                        st_ready_o,
    input  logic [2:0]                  st_funct3_i,
    input  logic [ADDR_WIDTH-1:0]       st_addr_i,
    input  logic [DATA_WIDTH-1:0]       st_wdata_i,
    input  logic [ROB_WIDTH-1:0]        st_rob_id_i,
    output logic [$clog2(SQ_DEPTH)-1:0] st_id_o,
    input  logic                        retire_st_valid_i,
    input  logic                        ld_valid_i,
    output logic                        ld_ready_o,
    input  logic [2:0]                  ld_funct3_i,
    input  logic [ADDR_WIDTH-1:0]       ld_addr_i,
    input  logic [ROB_WIDTH-1:0]        ld_rob_id_i,
    input  logic [PHY_WIDTH-1:0]        ld_rd_phy_i,
    output logic                        wb_valid_o,
    output logic [ROB_WIDTH-1:0]        wb_rob_id_o,
    output logic [PHY_WIDTH-1:0]        wb_rd_phy_o,
    output logic [DATA_WIDTH-1:0]       wb_data_o,
    output logic                        mem_rd_en_o,
    input  logic                        mem_rd_ready_i,
    output logic [ADDR_WIDTH-1:0]       mem_raddr_o,
    input  logic                        mem_rdata_valid_i,
    input  logic [DATA_WIDTH-1:0]       mem_rdata_i,
    output logic                        mem_wr_en_o,
    input  logic                        mem_wr_ready_i,
    output logic [ADDR_WIDTH-1:0]       mem_waddr_o,
    output logic [DATA_WIDTH-1:0]       mem_wdata_o,
    output logic [3:0]                  mem_wstrb_o
);
    localparam int SQ_IW = $clog2(SQ_DEPTH);
    localparam int SQ_PW = SQ_IW + 1;
    localparam int LQ_IW = $clog2(LQ_DEPTH);
    localparam int LQ_PW = LQ_IW + 1;
    localparam int WA    = ADDR_WIDTH - 2;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_WAIT, S_WB} ldState_e;

    // The ROB tag of a store is not needed once the ROB drives retire in order.
    logic unusedStRob;
    assign unusedStRob = ^st_rob_id_i;

    logic [WA-1:0]         sqAddr_q [SQ_DEPTH];
    logic [3:0]            sqMask_q [SQ_DEPTH];
    logic [DATA_WIDTH-1:0] sqData_q [SQ_DEPTH];
    logic [SQ_PW-1:0]      sqHead_q, sqCommit_q, sqTail_q;
    logic [SQ_PW-1:0]      sqHead_d, sqCommit_d, sqTail_d;

    logic [ADDR_WIDTH-1:0] ldAddr_q   [LQ_DEPTH];
    logic [2:0]            ldFunct3_q [LQ_DEPTH];
    logic [ROB_WIDTH-1:0]  ldRob_q    [LQ_DEPTH];
    logic [PHY_WIDTH-1:0]  ldPhy_q    [LQ_DEPTH];
    logic [SQ_PW-1:0]      ldSnap_q   [LQ_DEPTH];
    logic [LQ_PW-1:0]      lqHead_q, lqTail_q, lqHead_d, lqTail_d;

    ldState_e              state_q, state_d;
    logic [DATA_WIDTH-1:0] ldWord_q, ldWord_d;
    logic                  staleRead_q, staleRead_d;

    logic                  stEnq, ldEnq, doRetire, doDrain, lqPop;
    logic [3:0]            stMask;
    logic [DATA_WIDTH-1:0] stData;
    logic [ADDR_WIDTH-1:0] hAddr;
    logic [2:0]            hFunct3;
    logic [3:0]            ldMask, covered;
    logic [SQ_PW-1:0]      snapDist, scanPtr;
    logic [3:0]            fwdMask;
    logic [DATA_WIDTH-1:0] fwdData, extData;
    logic [7:0]            ldByte;
    logic [15:0]           ldHalf;

    assign st_ready_o = (sqTail_q - sqHead_q) != SQ_PW'(SQ_DEPTH);
    assign ld_ready_o = (lqTail_q - lqHead_q) != LQ_PW'(LQ_DEPTH);
    assign st_id_o    = sqTail_q[SQ_IW-1:0];
    assign stEnq      = st_valid_i && st_ready_o && !flush_i;
    assign ldEnq      = ld_valid_i && ld_ready_o && !flush_i;
    assign doRetire   = retire_st_valid_i && (sqCommit_q != sqTail_q);
    assign doDrain    = mem_wr_en_o && mem_wr_ready_i;
    assign lqPop      = wb_valid_o;

    // Store byte mask and lane-shifted data.
    always_comb begin
        stMask = 4'b0000;
        stData = '0;
        case (st_funct3_i)
            3'b000: begin
                stMask = 4'b0001 << st_addr_i[1:0];
                stData = {24'b0, st_wdata_i[7:0]} << {st_addr_i[1:0], 3'b000};
            end
            3'b001: begin
                stMask = st_addr_i[1] ? 4'b1100 : 4'b0011;
                stData = st_addr_i[1] ? {st_wdata_i[15:0], 16'b0} : {16'b0, st_wdata_i[15:0]};
            end
            3'b010: begin
                stMask = 4'b1111;
                stData = st_wdata_i;
            end
            default: ;
        endcase
    end

    // Store queue pointers. Flush rewinds tail to the (possibly just advanced)
    // commit pointer; draining of committed stores is unaffected.
    always_comb begin
        sqHead_d   = sqHead_q;
        sqCommit_d = sqCommit_q;
        sqTail_d   = sqTail_q;
        if (doDrain)  sqHead_d   = sqHead_q + 1'b1;
        if (doRetire) sqCommit_d = sqCommit_q + 1'b1;
        if (flush_i)    sqTail_d = sqCommit_d;
        else if (stEnq) sqTail_d = sqTail_q + 1'b1;
    end

    // Load queue pointers.
    always_comb begin
        lqHead_d = lqHead_q;
        lqTail_d = lqTail_q;
        if (lqPop) lqHead_d = lqHead_q + 1'b1;
        if (flush_i)    lqTail_d = lqHead_q;
        else if (ldEnq) lqTail_d = lqTail_q + 1'b1;
    end

    // Queue payloads carry no reset; occupancy is defined by the pointers.
    always_ff @(posedge clk) begin
        if (stEnq) begin
            sqAddr_q[sqTail_q[SQ_IW-1:0]] <= st_addr_i[ADDR_WIDTH-1:2];
            sqMask_q[sqTail_q[SQ_IW-1:0]] <= stMask;
            sqData_q[sqTail_q[SQ_IW-1:0]] <= stData;
        end
        if (ldEnq) begin
            ldAddr_q[lqTail_q[LQ_IW-1:0]]   <= ld_addr_i;
            ldFunct3_q[lqTail_q[LQ_IW-1:0]] <= ld_funct3_i;
            ldRob_q[lqTail_q[LQ_IW-1:0]]    <= ld_rob_id_i;
            ldPhy_q[lqTail_q[LQ_IW-1:0]]    <= ld_rd_phy_i;
            ldSnap_q[lqTail_q[LQ_IW-1:0]]   <= sqTail_q;
        end
    end

    assign hAddr   = ldAddr_q[lqHead_q[LQ_IW-1:0]];
    assign hFunct3 = ldFunct3_q[lqHead_q[LQ_IW-1:0]];

    always_comb begin
        ldMask = 4'b0000;
        case (hFunct3)
            3'b000, 3'b100: ldMask = 4'b0001 << hAddr[1:0];
            3'b001, 3'b101: ldMask = hAddr[1] ? 4'b1100 : 4'b0011;
            3'b010:         ldMask = 4'b1111;
            default:        ;
        endcase
    end

    // Forwarding scan over [sqHead, snapshot), walked oldest to youngest so a
    // younger store overwrites the bytes of an older one. A distance larger
    // than the queue means head has already moved past the snapshot.
    always_comb begin
        fwdMask  = 4'b0000;
        fwdData  = '0;
        scanPtr  = sqHead_q;
        snapDist = ldSnap_q[lqHead_q[LQ_IW-1:0]] - sqHead_q;
        for (int k = 0; k < SQ_DEPTH; k++) begin
            scanPtr = sqHead_q + SQ_PW'(k);
            if ((SQ_PW'(k) < snapDist) && (snapDist <= SQ_PW'(SQ_DEPTH)) &&
                (sqAddr_q[scanPtr[SQ_IW-1:0]] == hAddr[ADDR_WIDTH-1:2])) begin
                fwdMask = fwdMask | sqMask_q[scanPtr[SQ_IW-1:0]];
                for (int b = 0; b < 4; b++) begin
                    if (sqMask_q[scanPtr[SQ_IW-1:0]][b])
                        fwdData[8*b +: 8] = sqData_q[scanPtr[SQ_IW-1:0]][8*b +: 8];
                end
            end
        end
    end

    assign covered = fwdMask & ldMask;

    // Load FSM. staleRead_q remembers a read abandoned by a flush in WAIT so
    // that its late response is swallowed instead of completing a new load.
    always_comb begin
        state_d     = state_q;
        ldWord_d    = ldWord_q;
        staleRead_d = staleRead_q;
        mem_rd_en_o = 1'b0;
        if (staleRead_q && mem_rdata_valid_i) staleRead_d = 1'b0;
        case (state_q)
            S_IDLE:  if (lqHead_q != lqTail_q) state_d = S_CHECK;
            S_CHECK: begin
                if (covered == ldMask && covered != 4'b0000) begin
                    ldWord_d = fwdData;
                    state_d  = S_WB;
                end else if (covered == 4'b0000) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem_rd_en_o = 1'b1;
                if (mem_rd_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rdata_valid_i && !staleRead_q) begin
                    ldWord_d = mem_rdata_i;
                    state_d  = S_WB;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d     = S_IDLE;
            mem_rd_en_o = 1'b0;
            if (state_q == S_WAIT && !(mem_rdata_valid_i && !staleRead_q))
                staleRead_d = 1'b1;
        end
    end

    // Lane selection and sign/zero extension of the result word.
    always_comb begin
        ldByte  = ldWord_q[{hAddr[1:0], 3'b000} +: 8];
        ldHalf  = hAddr[1] ? ldWord_q[31:16] : ldWord_q[15:0];
        extData = '0;
        case (hFunct3)
            3'b000:  extData = {{24{ldByte[7]}}, ldByte};
            3'b001:  extData = {{16{ldHalf[15]}}, ldHalf};
            3'b010:  extData = ldWord_q;
            3'b100:  extData = {24'b0, ldByte};
            3'b101:  extData = {16'b0, ldHalf};
            default: extData = '0;
        endcase
    end

    assign wb_valid_o  = (state_q == S_WB) && !flush_i;
    assign wb_rob_id_o = wb_valid_o ? ldRob_q[lqHead_q[LQ_IW-1:0]] : '0;
    assign wb_rd_phy_o = wb_valid_o ? ldPhy_q[lqHead_q[LQ_IW-1:0]] : '0;
    assign wb_data_o   = wb_valid_o ? extData : '0;
    assign mem_raddr_o = mem_rd_en_o ? {hAddr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_wr_en_o = sqHead_q != sqCommit_q;
    assign mem_waddr_o = mem_wr_en_o ? {sqAddr_q[sqHead_q[SQ_IW-1:0]], 2'b00} : '0;
    assign mem_wdata_o = mem_wr_en_o ? sqData_q[sqHead_q[SQ_IW-1:0]] : '0;
    assign mem_wstrb_o = mem_wr_en_o ? sqMask_q[sqHead_q[SQ_IW-1:0]] : 4'b0000;

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sqHead_q    <= '0;
            sqCommit_q  <= '0;
            sqTail_q    <= '0;
            lqHead_q    <= '0;
            lqTail_q    <= '0;
            state_q     <= S_IDLE;
            ldWord_q    <= '0;
            staleRead_q <= 1'b0;
        end else begin
            sqHead_q    <= sqHead_d;
            sqCommit_q  <= sqCommit_d;
            sqTail_q    <= sqTail_d;
            lqHead_q    <= lqHead_d;
            lqTail_q    <= lqTail_d;
            state_q     <= state_d;
            ldWord_q    <= ldWord_d;
            staleRead_q <= staleRead_d;
        end
    end
endmodule

// File: tb/tb_load_store_queue_fwd.sv
// tb_load_store_queue_fwd
//   Directed bench for load_store_queue_fwd with a small memory model that
//   answers reads one cycle after the handshake and logs every write.
module tb_load_store_queue_fwd;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
    localparam logic [2:0] LB = 3'b000, LW = 3'b010, LBU = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, st_valid, st_ready, retire_st_valid;
    logic [2:0]  st_funct3, ld_funct3;
    logic [31:0] st_addr, st_wdata, ld_addr;
    logic [4:0]  st_rob_id, ld_rob_id, wb_rob_id;
    logic [2:0]  st_id;
    logic        ld_valid, ld_ready, wb_valid;
    logic [5:0]  ld_rd_phy, wb_rd_phy;
    logic [31:0] wb_data, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic        mem_rd_en, mem_rd_ready, mem_rdata_valid, mem_wr_en, mem_wr_ready;
    logic [3:0]  mem_wstrb;

    int testsRun = 0;
    int failCount = 0;

    logic        rdHold = 1'b0;
    logic        rdPending = 1'b0;
    logic [31:0] rdAddr = '0;
    logic [31:0] lastRdAddr = '0;
    int          rdReqCount = 0;
    logic [31:0] wrAddrLog[$];
    logic [31:0] wrDataLog[$];
    logic [3:0]  wrStrbLog[$];

    load_store_queue_fwd dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .st_valid_i(st_valid), .st_ready_o(st_ready), .st_funct3_i(st_funct3),
        .st_addr_i(st_addr), .st_wdata_i(st_wdata), .st_rob_id_i(st_rob_id), .st_id_o(st_id),
        .retire_st_valid_i(retire_st_valid),
        .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_funct3_i(ld_funct3),
        .ld_addr_i(ld_addr), .ld_rob_id_i(ld_rob_id), .ld_rd_phy_i(ld_rd_phy),
        .wb_valid_o(wb_valid), .wb_rob_id_o(wb_rob_id), .wb_rd_phy_o(wb_rd_phy), .wb_data_o(wb_data),
        .mem_rd_en_o(mem_rd_en), .mem_rd_ready_i(mem_rd_ready), .mem_raddr_o(mem_raddr),
        .mem_rdata_valid_i(mem_rdata_valid), .mem_rdata_i(mem_rdata),
        .mem_wr_en_o(mem_wr_en), .mem_wr_ready_i(mem_wr_ready), .mem_waddr_o(mem_waddr),
        .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memModel(input logic [31:0] a);
        case (a)
            32'h200: return 32'hAABBCC11;
            32'h040: return 32'h12345678;
            default: return 32'h0BAD0000 | {16'b0, a[15:0]};
        endcase
    endfunction

    // Read responder: data follows the accepted request by one cycle unless
    // rdHold keeps it back.
    initial begin
        mem_rdata_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rdPending && !rdHold) begin
                mem_rdata_valid = 1'b1;
                mem_rdata = memModel(rdAddr);
                rdPending = 1'b0;
            end else begin
                mem_rdata_valid = 1'b0;
            end
            if (mem_rd_en && mem_rd_ready) begin
                rdPending = 1'b1;
                rdAddr = mem_raddr;
                lastRdAddr = mem_raddr;
                rdReqCount++;
            end
        end
    end

    // Write monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_wr_en && mem_wr_ready) begin
                wrAddrLog.push_back(mem_waddr);
                wrDataLog.push_back(mem_wdata);
                wrStrbLog.push_back(mem_wstrb);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        st_valid = 1'b1; st_funct3 = f3; st_addr = a; st_wdata = d; st_rob_id = 5'd1;
        @(posedge clk); #1;
        st_valid = 1'b0;
    endtask

    task automatic applyLoad(input logic [2:0] f3, input logic [31:0] a,
                             input logic [4:0] rob, input logic [5:0] phy);
        @(negedge clk);
        ld_valid = 1'b1; ld_funct3 = f3; ld_addr = a; ld_rob_id = rob; ld_rd_phy = phy;
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic applyRetire();
        @(negedge clk);
        retire_st_valid = 1'b1;
        @(posedge clk); #1;
        retire_st_valid = 1'b0;
    endtask

    task automatic applyFlush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Latency n means wb_valid was first seen at the n-th falling edge after
    // the enqueue edge, i.e. it is sampled by the consumer at rising edge n.
    task automatic waitWb(input int limit, output bit found, output int lat,
                          output logic [31:0] data, output logic [4:0] rob, output logic [5:0] phy);
        found = 1'b0; lat = 0; data = '0; rob = '0; phy = '0;
        for (int n = 1; n <= limit && !found; n++) begin
            @(negedge clk);
            if (wb_valid) begin
                found = 1'b1; lat = n; data = wb_data; rob = wb_rob_id; phy = wb_rd_phy;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic clearLogs();
        wrAddrLog.delete(); wrDataLog.delete(); wrStrbLog.delete();
    endtask

    initial begin
        bit          found, wbSeen, rdSeen;
        int          lat, rdBefore;
        logic [31:0] data;
        logic [4:0]  rob;
        logic [5:0]  phy;

        rst = 1'b1; flush = 1'b0; st_valid = 1'b0; retire_st_valid = 1'b0; ld_valid = 1'b0;
        st_funct3 = '0; st_addr = '0; st_wdata = '0; st_rob_id = '0;
        ld_funct3 = '0; ld_addr = '0; ld_rob_id = '0; ld_rd_phy = '0;
        mem_rd_ready = 1'b1; mem_wr_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_st_ready", 32'(st_ready), 32'd1);
        checkOutput("rst_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        checkOutput("rst_st_id", 32'(st_id), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        waitCycles(1);

        // Word forward from an uncommitted store.
        rdBefore = rdReqCount;
        applyStore(SW, 32'h100, 32'hDEADBEEF);
        applyLoad(LW, 32'h100, 5'd1, 6'd2);
        waitWb(10, found, lat, data, rob, phy);
        checkOutput("fwd_found", 32'(found), 32'd1);
        checkOutput("fwd_latency", 32'(lat), 32'd3);
        checkOutput("fwd_data", data, 32'hDEADBEEF);
        checkOutput("fwd_rob", 32'(rob), 32'd1);
        checkOutput("fwd_phy", 32'(phy), 32'd2);
        checkOutput("fwd_no_read", 32'(rdReqCount - rdBefore), 32'd0);

        // Byte forward with sign and zero extension.
        applyStore(SB, 32'h103, 32'h00000080);
        applyLoad(LB, 32'h103, 5'd2, 6'd3);
        waitWb(10, found, lat, data, rob, phy);
        checkOutput("lb_data", data, 32'hFFFFFF80);
        applyLoad(LBU, 32'h103, 5'd3, 6'd4);
        waitWb(10, found, lat, data, rob, phy);
        checkOutput("lbu_data", data, 32'h00000080);

        applyRetire();
        applyRetire();
        waitCycles(4);
        checkOutput("drain2_count", 32'(wrAddrLog.size()), 32'd2);
        if (wrAddrLog.size() == 2) begin
            checkOutput("drain2_addr0", wrAddrLog[0], 32'h100);
            checkOutput("drain2_data0", wrDataLog[0], 32'hDEADBEEF);
            checkOutput("drain2_strb0", 32'(wrStrbLog[0]), 32'hF);
            checkOutput("drain2_data1", wrDataLog[1], 32'h80000000);
            checkOutput("drain2_strb1", 32'(wrStrbLog[1]), 32'h8);
        end
        clearLogs();

        // Partial overlap stalls until the store drains, then reads memory.
        applyStore(SB, 32'h200, 32'h00000011);
        applyLoad(LW, 32'h200, 5'd4, 6'd5);
        wbSeen = 1'b0; rdSeen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb_valid) wbSeen = 1'b1;
            if (mem_rd_en) rdSeen = 1'b1;
        end
        @(posedge clk); #1;
        checkOutput("stall_no_wb", 32'(wbSeen), 32'd0);
        checkOutput("stall_no_read", 32'(rdSeen), 32'd0);
        applyRetire();
        waitWb(20, found, lat, data, rob, phy);
        checkOutput("stall_found", 32'(found), 32'd1);
        checkOutput("stall_data", data, 32'hAABBCC11);
        checkOutput("stall_raddr", lastRdAddr, 32'h200);
        checkOutput("stall_wr_count", 32'(wrAddrLog.size()), 32'd1);
        if (wrAddrLog.size() == 1) begin
            checkOutput("stall_wr_addr", wrAddrLog[0], 32'h200);
            checkOutput("stall_wr_strb", 32'(wrStrbLog[0]), 32'h1);
            checkOutput("stall_wr_data", wrDataLog[0], 32'h11);
        end
        clearLogs();

        // Youngest store wins; a load older than both stores reads memory.
        mem_rd_ready = 1'b0;
        rdBefore = rdReqCount;
        applyLoad(LW, 32'h40, 5'd5, 6'd6);
        applyStore(SW, 32'h40, 32'd1);
        applyStore(SW, 32'h40, 32'd2);
        applyLoad(LW, 32'h40, 5'd6, 6'd7);
        mem_rd_ready = 1'b1;
        waitWb(20, found, lat, data, rob, phy);
        checkOutput("old_ld_rob", 32'(rob), 32'd5);
        checkOutput("old_ld_data", data, 32'h12345678);
        waitWb(20, found, lat, data, rob, phy);
        checkOutput("young_ld_rob", 32'(rob), 32'd6);
        checkOutput("young_ld_data", data, 32'd2);
        checkOutput("young_reads", 32'(rdReqCount - rdBefore), 32'd1);
        applyRetire();
        applyRetire();
        waitCycles(4);
        clearLogs();

        // Fill to full, ignored ninth store, then drain 20 across the wrap.
        for (int i = 0; i < 9; i++) begin
            applyStore(SW, 32'h1000 + 32'(4 * i), 32'(i));
            if (i == 6) checkOutput("full_ready_after7", 32'(st_ready), 32'd1);
            if (i == 7) checkOutput("full_ready_after8", 32'(st_ready), 32'd0);
        end
        for (int i = 0; i < 8; i++) applyRetire();
        for (int i = 8; i < 20; i++) begin
            applyStore(SW, 32'h1000 + 32'(4 * i), 32'(i));
            applyRetire();
        end
        waitCycles(6);
        checkOutput("wrap_count", 32'(wrAddrLog.size()), 32'd20);
        if (wrAddrLog.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                checkOutput($sformatf("wrap_addr%0d", i), wrAddrLog[i], 32'h1000 + 32'(4 * i));
                checkOutput($sformatf("wrap_data%0d", i), wrDataLog[i], 32'(i));
            end
        end
        clearLogs();

        // Flush with a committed store stuck in its write handshake and a
        // load waiting for read data.
        mem_wr_ready = 1'b0;
        applyStore(SW, 32'h300, 32'h55);
        applyStore(SW, 32'h304, 32'h66);
        applyRetire();
        rdHold = 1'b1;
        rdBefore = rdReqCount;
        applyLoad(LW, 32'h500, 5'd9, 6'd9);
        waitCycles(6);
        checkOutput("fl_read_issued", 32'(rdReqCount - rdBefore), 32'd1);
        checkOutput("fl_wr_pending", 32'(mem_wr_en), 32'd1);
        applyFlush();
        checkOutput("fl_wr_kept", 32'(mem_wr_en), 32'd1);
        mem_wr_ready = 1'b1;
        rdHold = 1'b0;
        wbSeen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_valid) wbSeen = 1'b1;
        end
        @(posedge clk); #1;
        checkOutput("fl_no_wb", 32'(wbSeen), 32'd0);
        checkOutput("fl_wr_count", 32'(wrAddrLog.size()), 32'd1);
        if (wrAddrLog.size() == 1) begin
            checkOutput("fl_wr_addr", wrAddrLog[0], 32'h300);
            checkOutput("fl_wr_data", wrDataLog[0], 32'h55);
        end
        checkOutput("fl_st_ready", 32'(st_ready), 32'd1);
        checkOutput("fl_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("fl_wr_idle", 32'(mem_wr_en), 32'd0);
        checkOutput("fl_rd_idle", 32'(mem_rd_en), 32'd0);
        applyLoad(LW, 32'h304, 5'd3, 6'd1);
        waitWb(20, found, lat, data, rob, phy);
        checkOutput("fl_post_found", 32'(found), 32'd1);
        checkOutput("fl_post_data", data, 32'h0BAD0304);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
